// File: rtl/wrr_vc_arbiter_if.sv
// VC-FIFO side (show-ahead heads, non-empty flags, pops) and output-stream side of the WRR arbiter.
// master = arbiter, slave = FIFOs plus downstream consumer.
interface wrr_vc_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] vc_data;
  logic [NUM_CH-1:0]        vc_valid;
  logic [NUM_CH-1:0]        vc_pop;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         grant_id;

  modport master (
    input  vc_data, vc_valid, out_ready,
    output vc_pop, out_data, out_valid, grant_id
  );

  modport slave (
    output vc_data, vc_valid, out_ready,
    input  vc_pop, out_data, out_valid, grant_id
  );
endinterface

// File: rtl/wrr_vc_arbiter.sv
// Weighted round-robin drain of NUM_CH VC FIFOs into one registered valid/ready stream (1-cycle pop-to-data);
// a stalled output freezes pops, ptr and credit. WRR_STRICT_CH0_EN makes channel 0 strict-priority.
module wrr_vc_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 4,
  parameter int WEIGHT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic [NUM_CH*WEIGHT_W-1:0] weights,
  wrr_vc_arbiter_if.master           bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [DATA_W-1:0]   data_a [NUM_CH];
  logic [WEIGHT_W-1:0] wt_a   [NUM_CH];
  logic [NUM_CH-1:0]   elig_raw;
  logic [NUM_CH-1:0]   elig;

  logic [IDX_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic [IDX_W-1:0]    grant_id_q;

  logic                adv;
  logic                strict_hit;
  logic                keep;
  logic                found;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    cand;
  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic [NUM_CH-1:0]   pop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign data_a[i]   = bus.vc_data[i*DATA_W +: DATA_W];
    assign wt_a[i]     = weights[i*WEIGHT_W +: WEIGHT_W];
    assign elig_raw[i] = bus.vc_valid[i] && (wt_a[i] != '0);
  end

`ifdef WRR_STRICT_CH0_EN
  // Channel 0 bypasses the weighted rotation entirely, so keep it out of the search.
  assign strict_hit = bus.vc_valid[0];
  assign elig       = elig_raw & ~NUM_CH'(1);
`else
  assign strict_hit = 1'b0;
  assign elig       = elig_raw;
`endif

  assign adv  = enb && rst && (!out_valid_q || bus.out_ready);
  assign keep = (credit != '0) && elig[ptr];

  // Circular search starting after ptr, with ptr itself considered last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    gnt_any = strict_hit || keep || found;
    if (strict_hit)
      gnt_idx = '0;
    else if (keep)
      gnt_idx = ptr;
    else
      gnt_idx = sel;
    pop = '0;
    if (adv && gnt_any)
      pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= IDX_W'(NUM_CH - 1);
      credit      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
    end else if (adv) begin
      if (!strict_hit) begin
        if (keep) begin
          credit <= credit - WEIGHT_W'(1);
        end else if (found) begin
          ptr    <= sel;
          credit <= wt_a[sel] - WEIGHT_W'(1);
        end
      end
      out_valid_q <= gnt_any;
      if (gnt_any) begin
        out_data_q <= data_a[gnt_idx];
        grant_id_q <= gnt_idx;
      end
    end
  end

  assign bus.vc_pop    = pop;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_wrr_vc_arbiter.sv
// Directed-vector bench for wrr_vc_arbiter at NUM_CH=4, DATA_W=4, WEIGHT_W=3; channel heads are A,B,C,D.
module tb_wrr_vc_arbiter;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 4;
  localparam int WEIGHT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [11:0] weights;
  int          checks   = 0;
  int          failures = 0;

  wrr_vc_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  wrr_vc_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .weights (weights),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, return just after the next rising edge.
  task automatic vec(input string tag, input logic [3:0] v, input logic rdy, input logic en,
                     input logic [3:0] ep, input logic ev, input logic [1:0] eg, input logic [3:0] ed);
    bus.vc_valid  = v;
    bus.out_ready = rdy;
    enb           = en;
    @(negedge clk);
    chk({tag, ".pop"}, 32'(bus.vc_pop), 32'(ep));
    chk({tag, ".vld"}, 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".gid"},  32'(bus.grant_id), 32'(eg));
      chk({tag, ".data"}, 32'(bus.out_data), 32'(ed));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag, input logic [11:0] w);
    rst     = 1'b0;
    weights = w;
    #1;
    chk({tag, ".rst_pop"},  32'(bus.vc_pop), 32'h0);
    chk({tag, ".rst_vld"},  32'(bus.out_valid), 32'h0);
    chk({tag, ".rst_data"}, 32'(bus.out_data), 32'h0);
    chk({tag, ".rst_gid"},  32'(bus.grant_id), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    enb           = 1'b1;
    weights       = 12'h249;
    bus.vc_data   = 16'hDCBA;
    bus.vc_valid  = 4'hF;
    bus.out_ready = 1'b1;
    #2;

`ifdef WRR_STRICT_CH0_EN
    // All weights 2; channel 0 shows up for two cycles in the middle of channel 2's burst.
    do_reset("s", 12'h492);
    vec("s.c0", 4'hE, 1, 1, 4'b0010, 0, 0, 0);
    vec("s.c1", 4'hE, 1, 1, 4'b0010, 1, 1, 4'hB);
    vec("s.c2", 4'hE, 1, 1, 4'b0100, 1, 1, 4'hB);
    vec("s.c3", 4'hF, 1, 1, 4'b0001, 1, 2, 4'hC);
    vec("s.c4", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("s.c5", 4'hE, 1, 1, 4'b0100, 1, 0, 4'hA);
    vec("s.c6", 4'hE, 1, 1, 4'b1000, 1, 2, 4'hC);
    vec("s.c7", 4'hE, 1, 1, 4'b1000, 1, 3, 4'hD);
`else
    // Reset with everything valid, then plain round robin at weight 1.
    do_reset("t1", 12'h249);
    for (int i = 0; i < 8; i++) begin
      vec($sformatf("t1.c%0d", i), 4'hF, 1, 1, 4'(1 << (i % 4)), i > 0,
          2'((i + 3) % 4), 4'(10 + ((i + 3) % 4)));
    end

    // Weights ch0=3 ch1=1 ch2=2 ch3=0: a,a,a,b,c,c then back to a.
    do_reset("t2", 12'h08B);
    vec("t2.c0", 4'hF, 1, 1, 4'b0001, 0, 0, 0);
    vec("t2.c1", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("t2.c2", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("t2.c3", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);
    vec("t2.c4", 4'hF, 1, 1, 4'b0100, 1, 1, 4'hB);
    vec("t2.c5", 4'hF, 1, 1, 4'b0100, 1, 2, 4'hC);
    vec("t2.c6", 4'hF, 1, 1, 4'b0001, 1, 2, 4'hC);
    vec("t2.c7", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);

    // All weights 2; ch1 empties after its first grant and forfeits the second credit.
    do_reset("t3", 12'h492);
    vec("t3.c0", 4'hF, 1, 1, 4'b0001, 0, 0, 0);
    vec("t3.c1", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("t3.c2", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);
    vec("t3.c3", 4'hD, 1, 1, 4'b0100, 1, 1, 4'hB);
    vec("t3.c4", 4'hD, 1, 1, 4'b0100, 1, 2, 4'hC);
    vec("t3.c5", 4'hD, 1, 1, 4'b1000, 1, 2, 4'hC);
    vec("t3.c6", 4'hD, 1, 1, 4'b1000, 1, 3, 4'hD);
    vec("t3.c7", 4'hD, 1, 1, 4'b0001, 1, 3, 4'hD);
    vec("t3.c8", 4'hD, 1, 1, 4'b0001, 1, 0, 4'hA);

    // Three stall cycles in the middle of ch1's burst.
    do_reset("t4", 12'h492);
    vec("t4.c0", 4'hF, 1, 1, 4'b0001, 0, 0, 0);
    vec("t4.c1", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("t4.c2", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);
    vec("t4.c3", 4'hF, 0, 1, 4'b0000, 1, 1, 4'hB);
    vec("t4.c4", 4'hF, 0, 1, 4'b0000, 1, 1, 4'hB);
    vec("t4.c5", 4'hF, 0, 1, 4'b0000, 1, 1, 4'hB);
    vec("t4.c6", 4'hF, 1, 1, 4'b0010, 1, 1, 4'hB);
    vec("t4.c7", 4'hF, 1, 1, 4'b0100, 1, 1, 4'hB);
    vec("t4.c8", 4'hF, 1, 1, 4'b0100, 1, 2, 4'hC);

    // Idle drain, then enable low on an idle and on a mid-burst state.
    vec("t5.c9",  4'h0, 1, 1, 4'b0000, 1, 2, 4'hC);
    vec("t5.c10", 4'h0, 1, 1, 4'b0000, 0, 0, 0);
    vec("t5.c11", 4'hF, 1, 0, 4'b0000, 0, 0, 0);
    vec("t5.c12", 4'hF, 1, 0, 4'b0000, 0, 0, 0);
    vec("t5.c13", 4'hF, 1, 1, 4'b1000, 0, 0, 0);
    vec("t5.c14", 4'hF, 1, 1, 4'b1000, 1, 3, 4'hD);
    vec("t5.c15", 4'hF, 1, 1, 4'b0001, 1, 3, 4'hD);
    vec("t5.c16", 4'hF, 1, 0, 4'b0000, 1, 0, 4'hA);
    vec("t5.c17", 4'hF, 1, 0, 4'b0000, 1, 0, 4'hA);
    vec("t5.c18", 4'hF, 1, 1, 4'b0001, 1, 0, 4'hA);
    vec("t5.c19", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);

    // Full weight 7 on ch0 (mid-burst reset above); lowering it mid-burst must not truncate the credit.
    do_reset("t6", 12'h00F);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) weights = 12'h009;
      vec($sformatf("t6.c%0d", i), 4'hF, 1, 1, 4'b0001, i > 0, 0, 4'hA);
    end
    vec("t6.c7", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);
    vec("t6.c8", 4'hF, 1, 1, 4'b0001, 1, 1, 4'hB);
    vec("t6.c9", 4'hF, 1, 1, 4'b0010, 1, 0, 4'hA);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
